// File: rtl/mat_add_axil_slave_if.sv
// ============================================================================
// Module      : mat_add_axil_slave_if
// Description : AXI4-Lite bus bundle between the processor/VIP master and the
//               mat_add register slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mat_add_axil_slave_if #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
);
   logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
   logic [2:0]                      S_AXI_AWPROT;
   logic                            S_AXI_AWVALID;
   logic                            S_AXI_AWREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
   logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
   logic                            S_AXI_WVALID;
   logic                            S_AXI_WREADY;
   logic [1:0]                      S_AXI_BRESP;
   logic                            S_AXI_BVALID;
   logic                            S_AXI_BREADY;
   logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
   logic [2:0]                      S_AXI_ARPROT;
   logic                            S_AXI_ARVALID;
   logic                            S_AXI_ARREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
   logic [1:0]                      S_AXI_RRESP;
   logic                            S_AXI_RVALID;
   logic                            S_AXI_RREADY;

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      output S_AXI_AWREADY,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_WREADY,
      output S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      output S_AXI_ARREADY,
      output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      input  S_AXI_RREADY
   );

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      input  S_AXI_AWREADY,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_WREADY,
      input  S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      input  S_AXI_ARREADY,
      input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      output S_AXI_RREADY
   );
endinterface

`default_nettype wire

// File: rtl/mat_add_axil_slave.sv
// ============================================================================
// Module      : mat_add_axil_slave
// Description : AXI4-Lite slave with four R/W registers exported to the
//               matrix-add datapath. Optional MAT_ADD_SUM_REG_EN adds a
//               read-only lane-wise byte sum of reg0/reg1 at offset 0x10.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mat_add_axil_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
) (
   input  wire logic                            ACLK,
   input  wire logic                            ARESET,
   mat_add_axil_slave_if.slave                  s_axi,
   output logic [4*C_S_AXI_DATA_WIDTH-1:0]      regs_o
);

   localparam int         C_IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
   localparam logic [1:0] C_OKAY   = 2'b00;
   localparam logic [1:0] C_SLVERR = 2'b10;
`ifdef MAT_ADD_SUM_REG_EN
   localparam logic [C_IDX_W-1:0] C_SUM_IDX = C_IDX_W'(4);
`endif

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_ACK = 2'd1, W_RESP = 2'd2} wstate_t;
   typedef enum logic [1:0] {R_IDLE = 2'd0, R_ACK = 2'd1, R_DATA = 2'd2} rstate_t;

   wstate_t                         wstate_q, wstate_d;
   rstate_t                         rstate_q, rstate_d;
   logic                            awready_q, awready_d;
   logic                            bvalid_q, bvalid_d;
   logic [1:0]                      bresp_q, bresp_d;
   logic                            arready_q, arready_d;
   logic                            rvalid_q, rvalid_d;
   logic [1:0]                      rresp_q, rresp_d;
   logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [C_S_AXI_DATA_WIDTH-1:0]   regs_q [4];
   logic [C_S_AXI_DATA_WIDTH-1:0]   regs_d [4];

   logic [C_IDX_W-1:0] w_widx, w_ridx;
   logic               w_wmapped, w_rmapped;
   logic               unused_ok;

   assign w_widx    = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign w_ridx    = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign w_wmapped = (w_widx[C_IDX_W-1:2] == '0);
   assign w_rmapped = (w_ridx[C_IDX_W-1:2] == '0);
   assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                        s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

`ifdef MAT_ADD_SUM_REG_EN
   logic [C_S_AXI_DATA_WIDTH-1:0] w_sum;
   always_comb begin
      w_sum = '0;
      for (int k = 0; k < C_S_AXI_DATA_WIDTH/8; k++) begin
         w_sum[8*k +: 8] = regs_q[0][8*k +: 8] + regs_q[1][8*k +: 8];
      end
   end
`endif

   // Write channel: address and data are only ever taken together.
   always_comb begin
      wstate_d  = wstate_q;
      awready_d = 1'b0;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      regs_d    = regs_q;
      case (wstate_q)
         W_IDLE: begin
            if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) begin
               wstate_d  = W_ACK;
               awready_d = 1'b1;
            end
         end
         W_ACK: begin
            wstate_d = W_RESP;
            bvalid_d = 1'b1;
            bresp_d  = C_SLVERR;
            if (w_wmapped) begin
               bresp_d = C_OKAY;
               for (int k = 0; k < C_S_AXI_DATA_WIDTH/8; k++) begin
                  if (s_axi.S_AXI_WSTRB[k]) begin
                     regs_d[w_widx[1:0]][8*k +: 8] = s_axi.S_AXI_WDATA[8*k +: 8];
                  end
               end
            end
`ifdef MAT_ADD_SUM_REG_EN
            if (w_widx == C_SUM_IDX) begin
               bresp_d = C_OKAY;
            end
`endif
         end
         W_RESP: begin
            if (s_axi.S_AXI_BREADY) begin
               wstate_d = W_IDLE;
               bvalid_d = 1'b0;
            end
         end
         default: wstate_d = W_IDLE;
      endcase
   end

   // Read data is sampled in R_ACK, so a same-edge write is not yet visible.
   always_comb begin
      rstate_d  = rstate_q;
      arready_d = 1'b0;
      rvalid_d  = rvalid_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;
      case (rstate_q)
         R_IDLE: begin
            if (s_axi.S_AXI_ARVALID) begin
               rstate_d  = R_ACK;
               arready_d = 1'b1;
            end
         end
         R_ACK: begin
            rstate_d = R_DATA;
            rvalid_d = 1'b1;
            rresp_d  = C_SLVERR;
            rdata_d  = '0;
            if (w_rmapped) begin
               rresp_d = C_OKAY;
               rdata_d = regs_q[w_ridx[1:0]];
            end
`ifdef MAT_ADD_SUM_REG_EN
            if (w_ridx == C_SUM_IDX) begin
               rresp_d = C_OKAY;
               rdata_d = w_sum;
            end
`endif
         end
         R_DATA: begin
            if (s_axi.S_AXI_RREADY) begin
               rstate_d = R_IDLE;
               rvalid_d = 1'b0;
            end
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wstate_q  <= W_IDLE;
         rstate_q  <= R_IDLE;
         awready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rresp_q   <= 2'b00;
         rdata_q   <= '0;
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         wstate_q  <= wstate_d;
         rstate_q  <= rstate_d;
         awready_q <= awready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         regs_q    <= regs_d;
      end
   end

   assign s_axi.S_AXI_AWREADY = awready_q;
   assign s_axi.S_AXI_WREADY  = awready_q;
   assign s_axi.S_AXI_BVALID  = bvalid_q;
   assign s_axi.S_AXI_BRESP   = bresp_q;
   assign s_axi.S_AXI_ARREADY = arready_q;
   assign s_axi.S_AXI_RVALID  = rvalid_q;
   assign s_axi.S_AXI_RRESP   = rresp_q;
   assign s_axi.S_AXI_RDATA   = rdata_q;
   assign regs_o = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};

endmodule

`default_nettype wire

// File: tb/tb_mat_add_axil_slave.sv
// ============================================================================
// Module      : tb_mat_add_axil_slave
// Description : Self-checking bench for mat_add_axil_slave; directed cases
//               plus random single-beat traffic against a register model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mat_add_axil_slave;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic [127:0] regs_o;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] model [4];

   mat_add_axil_slave_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) bus ();

   mat_add_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .s_axi  (bus.slave),
      .regs_o (regs_o)
   );

   always #5 ACLK = ~ACLK;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   function automatic logic [127:0] model_vec();
      return {model[3], model[2], model[1], model[0]};
   endfunction

   // Expected read result per the register map.
   task automatic exp_read(input int idx, output logic [31:0] data, output logic [1:0] resp);
      data = 32'h0;
      resp = 2'b10;
      if (idx < 4) begin
         data = model[idx];
         resp = 2'b00;
      end
`ifdef MAT_ADD_SUM_REG_EN
      if (idx == 4) begin
         for (int k = 0; k < 4; k++) begin
            data = data | (((((model[0] >> (8*k)) & 32'hFF) + ((model[1] >> (8*k)) & 32'hFF)) & 32'hFF) << (8*k));
         end
         resp = 2'b00;
      end
`endif
   endtask

   function automatic logic [1:0] exp_wresp(input int idx);
`ifdef MAT_ADD_SUM_REG_EN
      if (idx == 4) return 2'b00;
`endif
      return (idx < 4) ? 2'b00 : 2'b10;
   endfunction

   task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int lead, input int hold);
      int idx;
      logic [1:0] resp;
      idx = int'(addr[4:2]);
      resp = exp_wresp(idx);
      bus.S_AXI_AWADDR  = addr;
      bus.S_AXI_WDATA   = data;
      bus.S_AXI_WSTRB   = strb;
      bus.S_AXI_AWVALID = 1'b1;
      for (int i = 0; i < lead; i++) begin
         tick();
         check("aw_early_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 2'b00);
      end
      bus.S_AXI_WVALID = 1'b1;
      tick();
      check("wr_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 2'b11);
      tick();
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
      if (idx < 4) begin
         for (int k = 0; k < 4; k++) begin
            if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
         end
      end
      check("wr_ready_pulse", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 2'b00);
      check("bvalid", bus.S_AXI_BVALID, 1'b1);
      check("bresp", bus.S_AXI_BRESP, resp);
      check("regs_o", regs_o, model_vec());
      for (int i = 0; i < hold; i++) begin
         tick();
         check("bhold", {bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.S_AXI_AWREADY}, {1'b1, resp, 1'b0});
      end
      bus.S_AXI_BREADY = 1'b1;
      tick();
      bus.S_AXI_BREADY = 1'b0;
      check("bvalid_clr", bus.S_AXI_BVALID, 1'b0);
   endtask

   task automatic axi_read(input logic [4:0] addr, input int hold);
      int idx;
      logic [31:0] data;
      logic [1:0]  resp;
      idx = int'(addr[4:2]);
      exp_read(idx, data, resp);
      bus.S_AXI_ARADDR  = addr;
      bus.S_AXI_ARVALID = 1'b1;
      tick();
      check("arready", bus.S_AXI_ARREADY, 1'b1);
      tick();
      bus.S_AXI_ARVALID = 1'b0;
      check("arready_pulse", bus.S_AXI_ARREADY, 1'b0);
      check("rvalid", bus.S_AXI_RVALID, 1'b1);
      check("rdata", bus.S_AXI_RDATA, data);
      check("rresp", bus.S_AXI_RRESP, resp);
      for (int i = 0; i < hold; i++) begin
         tick();
         check("rhold", {bus.S_AXI_RVALID, bus.S_AXI_RRESP, bus.S_AXI_RDATA, bus.S_AXI_ARREADY},
               {1'b1, resp, data, 1'b0});
      end
      bus.S_AXI_RREADY = 1'b1;
      tick();
      bus.S_AXI_RREADY = 1'b0;
      check("rvalid_clr", bus.S_AXI_RVALID, 1'b0);
   endtask

   initial begin
      ARESET = 1'b1;
      bus.S_AXI_AWADDR = '0;  bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WDATA  = '0;  bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
      bus.S_AXI_BREADY = 1'b0;
      bus.S_AXI_ARADDR = '0;  bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
      bus.S_AXI_RREADY = 1'b0;
      for (int i = 0; i < 4; i++) model[i] = 32'h0;
      repeat (3) tick();
      ARESET = 1'b0;
      tick();
      check("rst_outputs", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_ARREADY,
                            bus.S_AXI_RVALID, bus.S_AXI_BRESP, bus.S_AXI_RRESP}, 9'h0);
      check("rst_rdata", bus.S_AXI_RDATA, 32'h0);
      check("rst_regs", regs_o, 128'h0);

      // Sequential writes then reads.
      for (int i = 0; i < 4; i++) axi_write(5'(4*i), 32'(i + 1), 4'hF, 0, 0);
      for (int i = 0; i < 4; i++) axi_read(5'(4*i), 0);
      check("seq_regs", regs_o, 128'h00000004_00000003_00000002_00000001);

      // Late WVALID with a single byte strobe.
      axi_write(5'h08, 32'h11223344, 4'hF, 0, 0);
      axi_write(5'h08, 32'hAABBCCDD, 4'b0010, 3, 0);
      check("strb_reg2", regs_o[95:64], 128'h1122CC44);

      // Back-pressure on both response channels.
      axi_write(5'h04, 32'hCAFEF00D, 4'hF, 0, 10);
      axi_read(5'h04, 10);

      // Unmapped addresses.
      axi_read(5'h14, 0);
      axi_write(5'h18, 32'hDEADBEEF, 4'hF, 0, 0);

      // Byte-sum word (or its absence).
      axi_write(5'h00, 32'h01FF8010, 4'hF, 0, 0);
      axi_write(5'h04, 32'h0101807F, 4'hF, 0, 0);
      axi_read(5'h10, 0);
      axi_write(5'h10, 32'h12345678, 4'hF, 1, 0);

      // Random single-beat traffic.
      for (int n = 0; n < 60; n++) begin
         logic [4:0] a;
         a = {3'($urandom_range(0, 7)), 2'($urandom)};
         if ($urandom_range(0, 1) == 0)
            axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
         else
            axi_read(a, $urandom_range(0, 3));
      end

      // Reset in the middle of an accepted write.
      bus.S_AXI_AWADDR  = 5'h0C;
      bus.S_AXI_WDATA   = 32'h55AA55AA;
      bus.S_AXI_WSTRB   = 4'hF;
      bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WVALID  = 1'b1;
      tick();
      ARESET = 1'b1;
      repeat (3) tick();
      check("midrst_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID,
                             bus.S_AXI_ARREADY, bus.S_AXI_RVALID}, 5'h0);
      check("midrst_regs", regs_o, 128'h0);
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
      ARESET = 1'b0;
      for (int i = 0; i < 4; i++) model[i] = 32'h0;
      repeat (4) begin
         tick();
         check("midrst_no_bvalid", bus.S_AXI_BVALID, 1'b0);
      end
      axi_read(5'h0C, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mat_add_axil_slave.md
# mat_add_axil_slave

AXI4-Lite responder for the mat_add peripheral: it terminates the S00_AXI port driven by the VIP master / processor, holds four 32-bit software-visible registers and exports them to the matrix-add datapath. It is the slave-side counterpart to the bus master that issues single-beat AXI4LITE write and read bursts to offsets 0x00–0x0C.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; bits [1:0] ignored, bits [4:2] select the word.

Ports:
- ACLK  in  1  sole clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- regs_o  out  128  {reg3, reg2, reg1, reg0} to datapath, registered.

## Operation
- Register map: reg0 0x00, reg1 0x04, reg2 0x08, reg3 0x0C, all read/write, reset 0.
- Write channel FSM: W_IDLE -> W_ACK -> W_RESP -> W_IDLE.
  - W_IDLE: wait until AWVALID and WVALID both high (same or different cycles); address and data are never accepted separately.
  - W_ACK: AWREADY=WREADY=1 for exactly one cycle; at that edge bytes with WSTRB[k]=1 are written; unmapped word -> no write.
  - W_RESP: BVALID=1, BRESP=OKAY (2'b00) for mapped, SLVERR (2'b10) for unmapped; held, BRESP stable, until BREADY; then W_IDLE.
- Read channel FSM: R_IDLE -> R_ACK -> R_DATA -> R_IDLE.
  - R_ACK: ARREADY=1 one cycle; RDATA captured from register at that edge (unmapped -> 0, RRESP=SLVERR).
  - R_DATA: RVALID=1, RDATA/RRESP stable until RREADY; then R_IDLE.
- Channels independent; simultaneous read and write to same register: read returns pre-write value.
- Only one outstanding transaction per channel; no new ready while BVALID/RVALID pending.
- ARESET in any state: all FSMs to IDLE, all registers 0; an in-flight transaction is dropped, no response issued.

## Timing
- Reset values: AWREADY, WREADY, BVALID, ARREADY, RVALID = 0; BRESP, RRESP = 0; RDATA = 0; regs_o = 0.
- Write: valids sampled high in cycle t -> ready high in t+1 -> register/regs_o updated at end of t+1 -> BVALID high from t+2. Minimum 3 cycles per write with BREADY tied high.
- Read: ARVALID in t -> ARREADY in t+1 -> RVALID from t+2. Minimum 3 cycles per read.
- BREADY/RREADY low: response held indefinitely; back-to-back transaction accepted earliest cycle after response handshake.
- No combinational path from any input to any output.

## Configuration
- MAT_ADD_SUM_REG_EN defined: adds read-only word 0x10 = lane-wise byte sum of reg0 and reg1 (four independent 8-bit adds, modulo 256, no carry between lanes), computed combinationally from registers, captured in R_ACK; writes to 0x10 ignored with BRESP OKAY.
- Undefined: 0x10 is unmapped (SLVERR on read and write, RDATA 0).

## Test plan
- Reset: hold ARESET 3 cycles mid-write -> all ready/valid 0, regs_o 0, no BVALID after release.
- Sequential writes 0x1,0x2,0x3,0x4 to 0x00..0x0C, then reads -> RDATA 0x1..0x4, all RESP OKAY, regs_o = 0x00000004_00000003_00000002_00000001.
- AWVALID 3 cycles before WVALID, WSTRB=4'b0010, data 0xAABBCCDD to 0x08 after reg2=0x11223344 -> reg2=0x1122CC44, single AWREADY/WREADY pulse.
- BREADY and RREADY held low 10 cycles -> BVALID/RVALID and RESP/RDATA stable, no second ARREADY/AWREADY.
- Read 0x14 and write 0x18 -> SLVERR, RDATA 0, no register changes.
- With MAT_ADD_SUM_REG_EN, reg0=0x01FF8010, reg1=0x0101807F -> read 0x10 returns 0x0200008F; without macro -> SLVERR.
